// File: rtl/reg_file_cell.sv
// reg_file_cell: one N-bit general-purpose register.
//
// The register clears on a synchronous, active-high reset. Otherwise it
// loads new data when its write enable is high. Reset wins over a
// simultaneous write.
//
// Ports:
//   clk    - system clock; the register updates on the rising edge
//   reset  - synchronous, active-high; clears the register
//   we_i   - write enable for this register (already address-decoded)
//   d_i    - N-bit write data
//   q_o    - N-bit current register contents
module reg_file_cell #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] data_q;
  logic [N-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (we_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file.sv
// reg_file: MIPS-style register file with 32 registers of N bits each.
//
// The file has two combinational read ports and one synchronous write port.
// Register 0 has no storage and always reads as zero, so any write to
// address 0 is discarded. There is no write-to-read bypass: in the cycle of
// a write, the read ports still return the old value. Reset clears
// registers 1-31, and a write in the same cycle as reset is lost.
//
// Ports:
//   clk               - system clock; all state updates on the rising edge
//   reset             - synchronous, active-high; clears all registers
//   Reg_Write_i       - write enable
//   Write_Register_i  - 5-bit write address
//   Read_Register_1_i - 5-bit read address, port 1
//   Read_Register_2_i - 5-bit read address, port 2
//   Write_Data_i      - N-bit write data
//   Read_Data_1_o     - contents of register at Read_Register_1_i
//   Read_Data_2_o     - contents of register at Read_Register_2_i
module reg_file #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Reg_Write_i,
  input  logic [4:0]   Write_Register_i,
  input  logic [4:0]   Read_Register_1_i,
  input  logic [4:0]   Read_Register_2_i,
  input  logic [N-1:0] Write_Data_i,
  output logic [N-1:0] Read_Data_1_o,
  output logic [N-1:0] Read_Data_2_o
);

  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  logic [N-1:0] regs [NUM_REGS];

  // Entry 0 feeds both read muxes as a hard zero; it has no cell behind it.
  assign regs[0] = '0;

  for (genvar k = 1; k < NUM_REGS; k++) begin : g_cell
    logic we;
    assign we = Reg_Write_i && (Write_Register_i == ADDR_W'(k));

    reg_file_cell #(
      .N (N)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .we_i  (we),
      .d_i   (Write_Data_i),
      .q_o   (regs[k])
    );
  end

  always_comb begin
    Read_Data_1_o = regs[Read_Register_1_i];
    Read_Data_2_o = regs[Read_Register_2_i];
  end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  localparam int N = 32;

  logic         clk;
  logic         reset;
  logic         Reg_Write_i;
  logic [4:0]   Write_Register_i;
  logic [4:0]   Read_Register_1_i;
  logic [4:0]   Read_Register_2_i;
  logic [N-1:0] Write_Data_i;
  logic [N-1:0] Read_Data_1_o;
  logic [N-1:0] Read_Data_2_o;

  reg_file #(.N(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .Reg_Write_i       (Reg_Write_i),
    .Write_Register_i  (Write_Register_i),
    .Read_Register_1_i (Read_Register_1_i),
    .Read_Register_2_i (Read_Register_2_i),
    .Write_Data_i      (Write_Data_i),
    .Read_Data_1_o     (Read_Data_1_o),
    .Read_Data_2_o     (Read_Data_2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [N-1:0] e1;
    logic [N-1:0] e2;
  } exp_t;

  exp_t exp_q[$];
  logic chk;
  int   vectors;
  int   miscompares;

  // Monitor: one vector is presented per cycle in which chk is raised,
  // and it is sampled on the falling edge.
  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s: output presented with empty scoreboard", "monitor");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        vectors++;
        if (Read_Data_1_o !== e.e1 || Read_Data_2_o !== e.e2) begin
          miscompares++;
          $display("FAIL %s: rd1=%h rd2=%h expected rd1=%h rd2=%h",
                   e.name, Read_Data_1_o, Read_Data_2_o, e.e1, e.e2);
        end
      end
    end
  end

  // Apply one cycle of inputs just after the rising edge. When chk_en is
  // set, push the expected read data for this cycle into the scoreboard.
  task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                     input logic [N-1:0] wd, input logic [4:0] ra1,
                     input logic [4:0] ra2, input logic chk_en,
                     input string name, input logic [N-1:0] e1,
                     input logic [N-1:0] e2);
    exp_t e;
    @(posedge clk);
    #1;
    reset             = rst;
    Reg_Write_i       = we;
    Write_Register_i  = wa;
    Write_Data_i      = wd;
    Read_Register_1_i = ra1;
    Read_Register_2_i = ra2;
    if (chk_en) begin
      e.name = name;
      e.e1   = e1;
      e.e2   = e2;
      exp_q.push_back(e);
      chk = 1'b1;
    end else begin
      chk = 1'b0;
    end
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    chk               = 1'b0;
    reset             = 1'b1;
    Reg_Write_i       = 1'b0;
    Write_Register_i  = '0;
    Write_Data_i      = '0;
    Read_Register_1_i = '0;
    Read_Register_2_i = '0;

    // Reset for one edge, then sweep every address on both ports.
    cyc(1, 0, 0, 0, 0, 0, 0, "", 0, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, "reset_sweep", 0, 0);
    end

    // Basic write/read.
    cyc(0, 1, 10, 32'd3, 0, 0, 0, "", 0, 0);
    cyc(0, 1, 4, 32'd20, 0, 10, 1, "rd2_reg10", 0, 32'd3);
    cyc(0, 0, 0, 0, 4, 10, 1, "dual_read", 32'd20, 32'd3);
    cyc(0, 0, 0, 0, 10, 4, 1, "rd2_reg4", 32'd3, 32'd20);

    // A write to register 0 must be discarded.
    cyc(0, 1, 0, 32'd1, 0, 0, 1, "reg0_during_write", 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, "reg0_after_write", 0, 0);

    // Write enable low: address and data are ignored.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 10, 32'hFFFF_FFFF, 10, 4, 1, "we_gate", 32'd3, 32'd20);
    end
    cyc(0, 0, 0, 0, 10, 10, 1, "we_gate_after", 32'd3, 32'd3);

    // No bypass: old value in the write cycle, new value after the edge.
    cyc(0, 1, 7, 32'hA5A5_A5A5, 7, 7, 1, "r7_before_edge", 0, 0);
    cyc(0, 0, 0, 0, 7, 7, 1, "r7_after_edge", 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    // Top address boundary.
    cyc(0, 1, 31, 32'hDEAD_BEEF, 31, 1, 1, "r31_before_edge", 0, 0);
    cyc(0, 0, 0, 0, 31, 1, 1, "r31_after_edge", 32'hDEAD_BEEF, 0);

    // Reset has priority over a simultaneous write and clears earlier writes.
    cyc(1, 1, 12, 32'd5, 4, 10, 1, "pre_reset", 32'd20, 32'd3);
    cyc(0, 0, 0, 0, 12, 4, 1, "post_reset_12_4", 0, 0);
    cyc(0, 0, 0, 0, 10, 7, 1, "post_reset_10_7", 0, 0);
    cyc(0, 0, 0, 0, 31, 12, 1, "post_reset_31_12", 0, 0);

    cyc(0, 0, 0, 0, 0, 0, 0, "", 0, 0);
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d entries left, expected 0", "scoreboard_drain",
               exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL %s: simulation time limit reached", "timeout");
    $fatal(1, "timeout");
  end

endmodule
